// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// stopwatch_counter : prescaled 1 Hz MM:SS BCD stopwatch, run/pause/clear/lap
// Rev 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int PRESCALE_W = 26
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] counter_0,
  output logic [3:0] counter_1,
  output logic [3:0] counter_2,
  output logic [3:0] counter_3,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_pause = 2'd2;

  localparam logic [PRESCALE_W-1:0] c_presc_max = PRESCALE_W'(TICK_DIV - 1);

  logic [1:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [3:0][3:0]       live_q, live_d;
  logic [3:0][3:0]       snap_q, snap_d;
  logic                  lap_hold_q, lap_hold_d;
  logic                  wrap_q, wrap_d;

  logic                  w_tick;
  logic                  w_rollover;
  logic [3:0][3:0]       w_live_inc;

  assign w_tick = (state_q == c_st_run) && (presc_q == c_presc_max);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= c_st_idle;
      presc_q    <= '0;
      live_q     <= '0;
      snap_q     <= '0;
      lap_hold_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      live_q     <= live_d;
      snap_q     <= snap_d;
      lap_hold_q <= lap_hold_d;
      wrap_q     <= wrap_d;
    end
  end

  // Next-state logic: clear beats start_stop; clear is a no-op while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (start_stop) state_d = c_st_run;
      end
      c_st_run: begin
        if (clear)           state_d = c_st_idle;
        else if (start_stop) state_d = c_st_pause;
      end
      c_st_pause: begin
        if (clear)           state_d = c_st_idle;
        else if (start_stop) state_d = c_st_run;
      end
      default: state_d = c_st_idle;
    endcase
  end

  // BCD cascade: each digit only advances when every lower digit wraps.
  always_comb begin
    w_live_inc = live_q;
    w_rollover = 1'b0;
    if (live_q[0] != 4'd9) begin
      w_live_inc[0] = live_q[0] + 4'd1;
    end else begin
      w_live_inc[0] = 4'd0;
      if (live_q[1] != 4'd5) begin
        w_live_inc[1] = live_q[1] + 4'd1;
      end else begin
        w_live_inc[1] = 4'd0;
        if (live_q[2] != 4'd9) begin
          w_live_inc[2] = live_q[2] + 4'd1;
        end else begin
          w_live_inc[2] = 4'd0;
          if (live_q[3] != 4'd5) begin
            w_live_inc[3] = live_q[3] + 4'd1;
          end else begin
            w_live_inc[3] = 4'd0;
            w_rollover    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    presc_d    = presc_q;
    live_d     = live_q;
    snap_d     = snap_q;
    lap_hold_d = lap_hold_q;
    wrap_d     = 1'b0;
    if (clear && (state_q != c_st_idle)) begin
      presc_d    = '0;
      live_d     = '0;
      snap_d     = '0;
      lap_hold_d = 1'b0;
    end else begin
      case (state_q)
        c_st_idle: begin
          if (start_stop) presc_d = '0;
        end
        c_st_run: begin
          // The count advances on a tick edge even when start_stop pauses.
          if (w_tick) begin
            presc_d = '0;
            live_d  = w_live_inc;
            wrap_d  = w_rollover;
          end else begin
            presc_d = presc_q + PRESCALE_W'(1);
          end
          if (!start_stop && lap) begin
            lap_hold_d = !lap_hold_q;
            if (!lap_hold_q) snap_d = live_q;
          end
        end
        c_st_pause: begin
          if (!start_stop && lap) lap_hold_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    counter_0  = lap_hold_q ? snap_q[0] : live_q[0];
    counter_1  = lap_hold_q ? snap_q[1] : live_q[1];
    counter_2  = lap_hold_q ? snap_q[2] : live_q[2];
    counter_3  = lap_hold_q ? snap_q[3] : live_q[3];
    running    = (state_q == c_st_run);
    lap_active = lap_hold_q;
    wrap       = wrap_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_counter : self-checking bench, seconds-level model plus
// hand-computed directed expectations.  Rev 1.0
// ============================================================================
module tb_stopwatch_counter;

  localparam int TICK_DIV = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] counter_0, counter_1, counter_2, counter_3;
  logic       running, lap_active, wrap;

  int checks   = 0;
  int failures = 0;

  stopwatch_counter #(.TICK_DIV(TICK_DIV), .PRESCALE_W(3)) dut (
    .CLK(CLK), .RST(RST), .start_stop(start_stop), .clear(clear), .lap(lap),
    .counter_0(counter_0), .counter_1(counter_1),
    .counter_2(counter_2), .counter_3(counter_3),
    .running(running), .lap_active(lap_active), .wrap(wrap)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: elapsed time as a plain seconds count, 0..3599.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  int m_state = M_IDLE;
  int m_presc = 0;
  int m_live  = 0;
  int m_snap  = 0;
  bit m_hold  = 0;
  bit m_wrap  = 0;

  function automatic int digit(input int secs, input int idx);
    case (idx)
      0:       return secs % 10;
      1:       return (secs / 10) % 6;
      2:       return (secs / 60) % 10;
      default: return secs / 600;
    endcase
  endfunction

  always @(posedge CLK) begin
    int  shown;
    bit  tick;
    int  old_live;
    if (!RST) begin
      m_state = M_IDLE; m_presc = 0; m_live = 0; m_snap = 0; m_hold = 0; m_wrap = 0;
    end else begin
      m_wrap   = 0;
      tick     = (m_state == M_RUN) && (m_presc == TICK_DIV - 1);
      old_live = m_live;
      if (clear && m_state != M_IDLE) begin
        m_state = M_IDLE; m_presc = 0; m_live = 0; m_snap = 0; m_hold = 0;
      end else if (m_state == M_IDLE) begin
        if (start_stop) begin m_state = M_RUN; m_presc = 0; end
      end else if (m_state == M_RUN) begin
        if (tick) begin
          m_presc = 0;
          m_wrap  = (m_live == 3599);
          m_live  = (m_live + 1) % 3600;
        end else begin
          m_presc++;
        end
        if (start_stop) m_state = M_PAUSE;
        else if (lap) begin
          if (!m_hold) begin m_hold = 1; m_snap = old_live; end
          else m_hold = 0;
        end
      end else begin
        if (start_stop) m_state = M_RUN;
        else if (lap) m_hold = 0;
      end
    end
    #1;
    shown = m_hold ? m_snap : m_live;
    chk("cyc_counter_0", counter_0, digit(shown, 0));
    chk("cyc_counter_1", counter_1, digit(shown, 1));
    chk("cyc_counter_2", counter_2, digit(shown, 2));
    chk("cyc_counter_3", counter_3, digit(shown, 3));
    chk("cyc_running", running, (m_state == M_RUN) ? 1 : 0);
    chk("cyc_lap_active", lap_active, m_hold);
    chk("cyc_wrap", wrap, m_wrap);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drive for exactly one rising edge, then return on the following negedge.
  task automatic pulse(input bit ss, input bit cl, input bit lp);
    start_stop = ss; clear = cl; lap = lp;
    @(negedge CLK);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic expect_time(input string tag, input int m1, input int m0,
                             input int s1, input int s0);
    chk({tag, "_c3"}, counter_3, m1);
    chk({tag, "_c2"}, counter_2, m0);
    chk({tag, "_c1"}, counter_1, s1);
    chk({tag, "_c0"}, counter_0, s0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset
    cycles(3);
    expect_time("rst_hold", 0, 0, 0, 0);
    chk("rst_hold_running", running, 0);
    RST = 1'b1;
    cycles(1);
    expect_time("rst_rel", 0, 0, 0, 0);
    chk("rst_rel_running", running, 0);
    chk("rst_rel_lap", lap_active, 0);
    chk("rst_rel_wrap", wrap, 0);

    // 2. Start and count 12 seconds
    pulse(1, 0, 0);
    chk("start_running", running, 1);
    cycles(3);
    chk("pre_first_inc_c0", counter_0, 0);
    cycles(1);
    chk("first_inc_c0", counter_0, 1);
    cycles(44);
    expect_time("count12", 0, 0, 1, 2);
    pulse(0, 1, 0);
    expect_time("clr_after_count", 0, 0, 0, 0);
    chk("clr_running", running, 0);

    // 3. Pause / resume with prescaler held at 2
    pulse(1, 0, 0);
    cycles(5);
    pulse(1, 0, 0);
    chk("pause_running", running, 0);
    chk("pause_c0", counter_0, 1);
    cycles(20);
    chk("paused_c0", counter_0, 1);
    pulse(1, 0, 0);
    chk("resume_running", running, 1);
    cycles(1);
    chk("resume_1_c0", counter_0, 1);
    cycles(1);
    chk("resume_2_c0", counter_0, 2);
    pulse(0, 1, 0);

    // 4. Lap hold
    pulse(1, 0, 0);
    cycles(12);
    expect_time("lap_pre", 0, 0, 0, 3);
    pulse(0, 0, 1);
    chk("lap_on", lap_active, 1);
    cycles(15);
    expect_time("lap_frozen", 0, 0, 0, 3);
    pulse(0, 0, 1);
    chk("lap_off", lap_active, 0);
    expect_time("lap_release", 0, 0, 0, 7);
    pulse(0, 0, 1);
    chk("lap_on2", lap_active, 1);
    pulse(0, 1, 0);
    expect_time("lap_clear", 0, 0, 0, 0);
    chk("lap_clear_lap", lap_active, 0);

    // 6. Priority
    pulse(1, 0, 0);
    cycles(2);
    pulse(1, 1, 1);
    expect_time("prio_all", 0, 0, 0, 0);
    chk("prio_all_running", running, 0);
    chk("prio_all_lap", lap_active, 0);
    pulse(1, 0, 0);
    cycles(3);
    pulse(1, 0, 0);
    chk("ss_on_tick_c0", counter_0, 1);
    chk("ss_on_tick_running", running, 0);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    cycles(3);
    pulse(0, 1, 0);
    expect_time("clr_on_tick", 0, 0, 0, 0);
    chk("clr_on_tick_wrap", wrap, 0);

    // 5. Wrap after 3600 seconds
    pulse(1, 0, 0);
    cycles(3600 * TICK_DIV - 4);
    expect_time("at_5959", 5, 9, 5, 9);
    cycles(3);
    chk("pre_wrap_wrap", wrap, 0);
    cycles(1);
    expect_time("wrapped", 0, 0, 0, 0);
    chk("wrap_pulse", wrap, 1);
    chk("wrap_running", running, 1);
    cycles(1);
    chk("wrap_gone", wrap, 0);
    cycles(3);
    chk("after_wrap_c0", counter_0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
